// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F_predPC register, PC select, byte-wide instruction memory
// with a preload port, instruction split and fetch status generation.
module fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [2:0]  f_stat,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [63:0] f_pc,
  output logic [63:0] f_predPC,
  output logic [63:0] F_predPC
);
  localparam int          AW  = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam int          NB  = 10;
  localparam logic [64:0] LIM = 65'(IMEM_BYTES);

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic       need_regids;
    logic       need_valc;
  } dec_t;

  logic [7:0]           mem [IMEM_BYTES];
  logic [NB-1:0][7:0]   ib;
  dec_t                 dec;
  logic                 instr_valid;
  logic                 imem_error;
  logic [3:0]           len;
  logic [64:0]          last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           F_predPC <= '0;
    else if (!F_stall) F_predPC <= f_predPC;
  end

  // no reset on the array: the program survives a pipeline reset
  always_ff @(posedge clk) begin
    if (imem_we && ({1'b0, imem_waddr} < LIM))
      mem[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  always_comb begin
    if (M_icode == 4'h7 && !M_Cnd) f_pc = M_valA;
    else if (W_icode == 4'h9)      f_pc = W_valM;
    else                           f_pc = F_predPC;
  end

  // 65-bit addresses so a wrap past 2^64-1 lands out of range
  for (genvar i = 0; i < NB; i++) begin : g_rd
    logic [64:0] a;
    assign a     = {1'b0, f_pc} + 65'(i);
    assign ib[i] = (a < LIM) ? mem[a[AW-1:0]] : 8'h00;
  end

  always_comb begin
    dec.icode       = ib[0][7:4];
    dec.ifun        = ib[0][3:0];
    dec.need_regids = dec.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    dec.need_valc   = dec.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  end

  always_comb begin
    case (dec.icode)
      4'h6:                   instr_valid = (dec.ifun <= 4'd3);
      4'h2, 4'h7:             instr_valid = (dec.ifun <= 4'd6);
      4'hC, 4'hD, 4'hE, 4'hF: instr_valid = 1'b0;
      default:                instr_valid = (dec.ifun == 4'd0);
    endcase
  end

  assign len        = 4'd1 + {3'b0, dec.need_regids} + {dec.need_valc, 3'b0};
  assign last       = {1'b0, f_pc} + {61'b0, len} - 65'd1;
  assign imem_error = (last >= LIM);

  assign f_valP   = f_pc + {60'b0, len};
  assign f_valC   = !dec.need_valc   ? 64'h0 :
                    dec.need_regids  ? ib[9:2] : ib[8:1];
  assign f_rA     = dec.need_regids ? ib[1][7:4] : 4'hF;
  assign f_rB     = dec.need_regids ? ib[1][3:0] : 4'hF;
  assign f_icode  = imem_error ? 4'h1 : dec.icode;
  assign f_ifun   = imem_error ? 4'h0 : dec.ifun;
  assign f_predPC = (dec.icode == 4'h7 || dec.icode == 4'h8) ? f_valC : f_valP;

  always_comb begin
    if (imem_error)            f_stat = 3'd3;
    else if (!instr_valid)     f_stat = 3'd4;
    else if (dec.icode == 4'h0) f_stat = 3'd2;
    else                       f_stat = 3'd1;
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instruction-length table model checked every cycle,
// plus directed programs with hand-computed expectations.
`timescale 1ns/1ps
module tb_fetch_stage;
  logic        clk, rst, F_stall, M_Cnd, imem_we;
  logic [3:0]  M_icode, W_icode;
  logic [63:0] M_valA, W_valM, imem_waddr;
  logic [7:0]  imem_wdata;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP, f_pc, f_predPC, F_predPC;

  fetch_stage #(.IMEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_pc(f_pc), .f_predPC(f_predPC),
    .F_predPC(F_predPC));

  initial begin clk = 0; forever #10 clk = ~clk; end

  int checks = 0, failures = 0;
  logic cmp_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc, predPC;
  } exp_t;

  logic [7:0]  mm [1024];
  logic [63:0] mpc;

  always @(posedge clk)
    if (imem_we && imem_waddr < 64'd1024) mm[imem_waddr[9:0]] <= imem_wdata;

  function automatic logic [7:0] rd(logic [63:0] pc, int i);
    logic [64:0] a;
    a = {1'b0, pc} + 65'(i);
    if (a < 65'd1024) return mm[a[9:0]];
    return 8'h00;
  endfunction

  function automatic exp_t model_f();
    exp_t e;
    logic [7:0] b0, b1;
    logic [3:0] ic;
    int len;
    logic err, valid;
    if (M_icode == 4'h7 && !M_Cnd) e.pc = M_valA;
    else if (W_icode == 4'h9)      e.pc = W_valM;
    else                           e.pc = mpc;
    b0 = rd(e.pc, 0);
    ic = b0[7:4];
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h3, 4'h4, 4'h5:       len = 10;
      4'h7, 4'h8:             len = 9;
      default:                len = 1;
    endcase
    b1 = rd(e.pc, 1);
    e.rA = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
    e.rB = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
    e.valC = 64'h0;
    if (len >= 9)
      for (int k = 0; k < 8; k++) e.valC[8*k +: 8] = rd(e.pc, len - 8 + k);
    e.valP = e.pc + 64'(len);
    err = 0;
    for (int i = 0; i < len; i++)
      if ({1'b0, e.pc} + 65'(i) >= 65'd1024) err = 1;
    case (ic)
      4'h2, 4'h7: valid = b0[3:0] < 4'd7;
      4'h6:       valid = b0[3:0] < 4'd4;
      4'hC, 4'hD, 4'hE, 4'hF: valid = 0;
      default:    valid = b0[3:0] == 4'd0;
    endcase
    e.stat   = err ? 3'd3 : !valid ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
    e.icode  = err ? 4'h1 : ic;
    e.ifun   = err ? 4'h0 : b0[3:0];
    e.predPC = (ic == 4'h7 || ic == 4'h8) ? e.valC : e.valP;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)           mpc <= 64'h0;
    else if (!F_stall) mpc <= model_f().predPC;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = model_f();
      chk("cyc_stat",  64'(f_stat),  64'(e.stat));
      chk("cyc_icode", 64'(f_icode), 64'(e.icode));
      chk("cyc_ifun",  64'(f_ifun),  64'(e.ifun));
      chk("cyc_rA",    64'(f_rA),    64'(e.rA));
      chk("cyc_rB",    64'(f_rB),    64'(e.rB));
      chk("cyc_valC",  f_valC,   e.valC);
      chk("cyc_valP",  f_valP,   e.valP);
      chk("cyc_pc",    f_pc,     e.pc);
      chk("cyc_pred",  f_predPC, e.predPC);
      chk("cyc_Freg",  F_predPC, mpc);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] prog [1024];

  task automatic put(int a, logic [79:0] b, int n);
    for (int k = 0; k < n; k++) prog[a + k] = b[8*k +: 8];
  endtask

  task automatic redir(logic [63:0] a);
    @(posedge clk); #1;
    M_icode = 4'h7; M_Cnd = 0; M_valA = a;
    #1;
  endtask

  initial begin
    rst = 1; F_stall = 0; M_icode = 0; M_Cnd = 0; M_valA = 0;
    W_icode = 0; W_valM = 0; imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    for (int a = 0; a < 1024; a++) prog[a] = 8'h00;
    put(0,     80'h00_00_00_00_00_00_00_0A_F4_30, 10); // irmovq $10,%rsp
    put(8'h20, 80'h00_00_00_00_00_00_01_00_70, 9);     // jmp 0x100
    put(8'h50, 80'h00_00_00_00_00_00_02_00_80, 9);     // call 0x200
    put(8'h70, 80'h01_63, 2);                          // xorq %rax,%rcx
    put(1019,  80'h00_00_0A_F4_30, 5);                 // truncated irmovq
    prog[8'h13] = 8'h10; prog[8'h14] = 8'h10; prog[8'h2F] = 8'h10;
    prog[8'h60] = 8'hC0; prog[8'h61] = 8'h64; prog[1023] = 8'h10;

    // program loads while rst is held
    imem_we = 1;
    for (int a = 0; a < 1024; a++) begin
      imem_waddr = 64'(a); imem_wdata = prog[a];
      @(posedge clk); #1;
    end
    imem_we = 0;
    chk("rst_Freg", F_predPC, 64'h0);
    chk("rst_pc",   f_pc,     64'h0);
    cmp_en = 1;

    // irmovq at 0
    @(posedge clk); #1 rst = 0; #1;
    chk("t1_icode", 64'(f_icode), 64'h3);
    chk("t1_rA",    64'(f_rA),    64'hF);
    chk("t1_rB",    64'(f_rB),    64'h4);
    chk("t1_valC",  f_valC,   64'd10);
    chk("t1_valP",  f_valP,   64'd10);
    chk("t1_pred",  f_predPC, 64'd10);
    chk("t1_stat",  64'(f_stat),  64'h1);
    @(posedge clk); #1;
    chk("t1_Freg",  F_predPC, 64'd10);

    // jXX and mispredict/ret priority
    redir(64'h20);
    chk("t2_pc",    f_pc,     64'h20);
    chk("t2_icode", 64'(f_icode), 64'h7);
    chk("t2_valC",  f_valC,   64'h100);
    chk("t2_valP",  f_valP,   64'h29);
    chk("t2_pred",  f_predPC, 64'h100);
    @(posedge clk); #1;
    M_valA = 64'h29; #1;
    chk("t2_misp",  f_pc, 64'h29);
    W_icode = 4'h9; W_valM = 64'h40; #1;
    chk("t2_prio",  f_pc, 64'h29);
    M_icode = 0; #1;
    chk("t2_ret",   f_pc, 64'h40);
    W_icode = 0; #1;
    chk("t2_freg",  f_pc, 64'h100);

    // call then ret
    redir(64'h50);
    chk("t6_valP",  f_valP,   64'h59);
    chk("t6_pred",  f_predPC, 64'h200);
    @(posedge clk); #1;
    M_icode = 0; W_icode = 4'h9; W_valM = 64'h59; #1;
    chk("t6_ret",   f_pc, 64'h59);
    W_icode = 0;

    // stall holds F_predPC
    redir(64'h13);
    @(posedge clk); #1;
    M_icode = 0; F_stall = 1;
    chk("t3_pre",   F_predPC, 64'h14);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("t3_hold", F_predPC, 64'h14);
    end
    F_stall = 0;
    @(posedge clk); #1;
    chk("t3_rel",   F_predPC, 64'h15);

    // status cases and address boundaries
    redir(64'd1019);
    chk("t4_adr",    64'(f_stat),  64'h3);
    chk("t4_nop",    64'(f_icode), 64'h1);
    chk("t4_valP",   f_valP,   64'h405);
    redir(64'h60);
    chk("t4_C0",     64'(f_stat),  64'h4);
    redir(64'h61);
    chk("t4_64",     64'(f_stat),  64'h4);
    redir(64'h62);
    chk("t4_hlt",    64'(f_stat),  64'h2);
    redir(64'h70);
    chk("t4_opq",    64'(f_stat),  64'h1);
    chk("t4_opqP",   f_valP,   64'h72);
    chk("t4_opqB",   64'(f_rB),    64'h1);
    redir(64'd1023);
    chk("t4_last",   64'(f_stat),  64'h1);
    chk("t4_lastP",  f_valP,   64'h400);
    redir(64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_wrap",   64'(f_stat),  64'h3);
    chk("t4_wrapP",  f_valP,   64'h0);
    @(posedge clk); #1;
    M_Cnd = 1; #1;
    chk("t4_taken",  f_pc, 64'h0);
    M_icode = 0; M_Cnd = 0;

    // out-of-range write ignored, same-cycle write reads old byte
    imem_we = 1; imem_waddr = 64'd1024; imem_wdata = 8'hFF;
    @(posedge clk); #1 imem_we = 0;
    redir(64'h0);
    chk("w_oor",     64'(f_icode), 64'h3);
    redir(64'h13);
    imem_we = 1; imem_waddr = 64'h13; imem_wdata = 8'h00; #1;
    chk("w_old",     64'(f_icode), 64'h1);
    redir(64'h13);
    imem_we = 0; #1;
    chk("w_new",     64'(f_stat),  64'h2);

    // async reset mid-run while stalled
    redir(64'h2F);
    @(posedge clk); #1;
    M_icode = 0; F_stall = 1;
    chk("t5_pre",    F_predPC, 64'h30);
    #2 rst = 1; #1;
    chk("t5_async",  F_predPC, 64'h0);
    @(posedge clk); #1 rst = 0; F_stall = 0; #1;
    chk("t5_mem",    64'(f_icode), 64'h3);
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
